// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants, types and the write-enable decode.
//   REG_COUNT  number of architectural registers
//   ZERO_REG   hard-wired zero register; writes to it are dropped
//   reg_addr_t register index type
//   wb_grant_t write-port grant owner for one cycle
package regfile_pkg;
    localparam int REG_COUNT = 32;
    localparam logic [4:0] ZERO_REG = 5'd31;
    typedef logic [4:0] reg_addr_t;
    typedef enum logic [1:0] {GRANT_NONE, GRANT_PIPE, GRANT_AUX} wb_grant_t;
    function automatic logic [REG_COUNT-1:0] wr_onehot(input reg_addr_t a);
        return (a == ZERO_REG) ? '0 : ({{(REG_COUNT-1){1'b0}}, 1'b1} << a);
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding pending auxiliary writebacks.
//   clk, reset_n  clock and synchronous active-low reset (empties the FIFO)
//   push, wdata   enqueue request and entry; ignored when full
//   pop           dequeue the head; ignored when empty
//   rdata         current head entry (registered storage, no bypass)
//   full, empty   occupancy flags from registered count
//   count         occupancy 0..DEPTH
module wb_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] P_ONE = 1;
    localparam logic [CW-1:0] C_ONE = 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + P_ONE : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + P_ONE : rd_ptr_q;
        count_d  = (do_push && !do_pop) ? count_q + C_ONE :
                   (do_pop && !do_push) ? count_q - C_ONE : count_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline and auxiliary writebacks onto the single register-file write port.
//   clk, reset_n             clock and synchronous active-low reset
//   pipe_valid/addr/data     pipeline writeback, always consumed unless pipe_stall
//   pipe_stall               forced-auxiliary cycle; pipeline holds pipe_* into the next cycle
//   aux_valid/addr/data      auxiliary write request, accepted when aux_ready
//   aux_ready                auxiliary FIFO has room
//   rf_wr, rf_in             one-hot write enable and write data to the register file
//   aux_pending              auxiliary writes still queued, for hazard logic
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pipe_valid,
    input  logic [4:0]       pipe_addr,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             pipe_stall,
    input  logic             aux_valid,
    output logic             aux_ready,
    input  logic [4:0]       aux_addr,
    input  logic [WIDTH-1:0] aux_data,
    output logic [31:0]      rf_wr,
    output logic [WIDTH-1:0] rf_in,
    output logic             aux_pending
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] S_ONE = 1;
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
    logic [WIDTH+4:0] head;
    logic [CW-1:0] fifo_cnt;
    logic fifo_full, fifo_empty, forced;
    logic [SW-1:0] starve_q, starve_d;
    wb_grant_t grant;
    reg_addr_t wr_addr;
    wb_fifo #(.WIDTH(WIDTH + 5), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (aux_valid && aux_ready),
        .pop     (grant == GRANT_AUX),
        .wdata   ({aux_addr, aux_data}),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );
    assign forced      = !fifo_empty && (starve_q == S_MAX);
    assign pipe_stall  = reset_n && forced;
    assign aux_ready   = reset_n && !fifo_full;
    assign aux_pending = reset_n && (fifo_cnt != '0);
    // Holding the grant at NONE during reset keeps rf_wr quiet and blocks any dequeue.
    always_comb begin
        grant    = !reset_n ? GRANT_NONE :
                   (!fifo_empty && (!pipe_valid || forced)) ? GRANT_AUX :
                   pipe_valid ? GRANT_PIPE : GRANT_NONE;
        wr_addr  = (grant == GRANT_AUX) ? head[WIDTH+4:WIDTH] : pipe_addr;
        rf_wr    = (grant == GRANT_NONE) ? '0 : wr_onehot(wr_addr);
        rf_in    = (grant == GRANT_AUX) ? head[WIDTH-1:0] :
                   (grant == GRANT_PIPE) ? pipe_data : '0;
        starve_d = (fifo_empty || grant == GRANT_AUX) ? '0 :
                   (starve_q == S_MAX) ? starve_q : starve_q + S_ONE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 64;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic clk = 0;
    logic reset_n = 0;
    logic pipe_valid = 0;
    logic [4:0] pipe_addr = 0;
    logic [WIDTH-1:0] pipe_data = 0;
    logic aux_valid = 0;
    logic [4:0] aux_addr = 0;
    logic [WIDTH-1:0] aux_data = 0;
    logic pipe_stall, aux_ready, aux_pending;
    logic [31:0] rf_wr;
    logic [WIDTH-1:0] rf_in;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pipe_valid  (pipe_valid),
        .pipe_addr   (pipe_addr),
        .pipe_data   (pipe_data),
        .pipe_stall  (pipe_stall),
        .aux_valid   (aux_valid),
        .aux_ready   (aux_ready),
        .aux_addr    (aux_addr),
        .aux_data    (aux_data),
        .rf_wr       (rf_wr),
        .rf_in       (rf_in),
        .aux_pending (aux_pending)
    );

    typedef struct {
        logic rst_n;
        logic pv;
        logic [4:0] pa;
        logic [63:0] pd;
        logic av;
        logic [4:0] aa;
        logic [63:0] ad;
        logic [31:0] wr;
        logic [63:0] din;
        logic stall;
        logic ready;
        logic pend;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        logic [4:0] a;
        logic [63:0] d;
    } ent_t;
    ent_t mq[$];
    int starve = 0;

    task automatic add(input logic r, input logic pv, input logic [4:0] pa, input logic [63:0] pd,
                       input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic [31:0] wr, input logic [63:0] din,
                       input logic st, input logic rdy, input logic pe);
        vec_t v;
        v.rst_n = r; v.pv = pv; v.pa = pa; v.pd = pd; v.av = av; v.aa = aa; v.ad = ad;
        v.wr = wr; v.din = din; v.stall = st; v.ready = rdy; v.pend = pe;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant decision from the queue contents and the starvation count.
    function automatic int m_grant();
        bit ne = mq.size() > 0;
        bit forced = ne && starve == LIM;
        if (!reset_n) return 0;
        if (ne && (!pipe_valid || forced)) return 2;
        return pipe_valid ? 1 : 0;
    endfunction

    function automatic bit m_forced();
        return reset_n && mq.size() > 0 && starve == LIM;
    endfunction

    task automatic model_check();
        int g = m_grant();
        logic [4:0] a = (g == 2) ? mq[0].a : pipe_addr;
        logic [63:0] d = (g == 2) ? mq[0].d : pipe_data;
        logic [31:0] one = 32'd1;
        logic [31:0] ew = (g == 0 || a == 5'd31) ? 32'd0 : (one << a);
        chk("m_rf_wr", 64'(rf_wr), 64'(ew));
        if (g != 0) chk("m_rf_in", rf_in, d);
        chk("m_stall", 64'(pipe_stall), 64'(m_forced()));
        chk("m_ready", 64'(aux_ready), 64'(reset_n && mq.size() < DEPTH));
        chk("m_pend", 64'(aux_pending), 64'(reset_n && mq.size() > 0));
    endtask

    task automatic model_edge();
        int g;
        bit ne, acc;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            starve = 0;
            return;
        end
        g = m_grant();
        ne = mq.size() > 0;
        acc = aux_valid && mq.size() < DEPTH;
        if (g == 2) void'(mq.pop_front());
        starve = (!ne || g == 2) ? 0 : (starve < LIM ? starve + 1 : LIM);
        if (acc) begin
            e.a = aux_addr;
            e.d = aux_data;
            mq.push_back(e);
        end
    endtask

    // One cycle: inputs were driven at the falling edge; outputs sampled before the rising edge.
    task automatic cycle(input bit use_model);
        #2;
        if (use_model) model_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        bit hold;
        @(negedge clk);
        // rst pv pa pd av aa ad | rf_wr rf_in stall ready pend
        add(0, 1, 3, 64'hAA, 1, 2, 64'h22, 32'h0, 64'h0, 0, 0, 0);
        add(1, 1, 3, 64'hAA, 0, 0, 64'h0, 32'h8, 64'hAA, 0, 1, 0);
        add(1, 1, 31, 64'h77, 0, 0, 64'h0, 32'h0, 64'h0, 0, 1, 0);
        add(1, 0, 0, 64'h0, 1, 5, 64'h55, 32'h0, 64'h0, 0, 1, 0);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h20, 64'h55, 0, 1, 1);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 64'h0, 0, 1, 0);
        add(1, 1, 1, 64'h1, 1, 6, 64'h6, 32'h2, 64'h1, 0, 1, 0);
        add(1, 1, 2, 64'h2, 1, 7, 64'h7, 32'h4, 64'h2, 0, 1, 1);
        add(1, 1, 3, 64'h3, 1, 8, 64'h8, 32'h8, 64'h3, 0, 0, 1);
        add(1, 1, 4, 64'h4, 1, 8, 64'h8, 32'h10, 64'h4, 0, 0, 1);
        add(1, 1, 5, 64'h5, 1, 8, 64'h8, 32'h20, 64'h5, 0, 0, 1);
        add(1, 1, 9, 64'h9, 1, 8, 64'h8, 32'h40, 64'h6, 1, 0, 1);
        add(1, 1, 9, 64'h9, 1, 8, 64'h8, 32'h200, 64'h9, 0, 1, 1);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h80, 64'h7, 0, 0, 1);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h100, 64'h8, 0, 1, 1);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 64'h0, 0, 1, 0);
        add(1, 0, 0, 64'h0, 1, 10, 64'hA0, 32'h0, 64'h0, 0, 1, 0);
        add(1, 1, 11, 64'h11, 0, 0, 64'h0, 32'h800, 64'h11, 0, 1, 1);
        add(1, 1, 12, 64'h12, 0, 0, 64'h0, 32'h1000, 64'h12, 0, 1, 1);
        add(1, 1, 13, 64'h13, 0, 0, 64'h0, 32'h2000, 64'h13, 0, 1, 1);
        add(1, 1, 14, 64'h14, 0, 0, 64'h0, 32'h4000, 64'h14, 0, 1, 1);
        add(1, 1, 15, 64'h15, 0, 0, 64'h0, 32'h400, 64'hA0, 1, 1, 1);
        add(1, 1, 15, 64'h15, 0, 0, 64'h0, 32'h8000, 64'h15, 0, 1, 0);
        add(1, 0, 0, 64'h0, 1, 16, 64'h16, 32'h0, 64'h0, 0, 1, 0);
        add(1, 1, 20, 64'h20, 1, 17, 64'h17, 32'h100000, 64'h20, 0, 1, 1);
        add(0, 1, 21, 64'h21, 0, 0, 64'h0, 32'h0, 64'h0, 0, 0, 0);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 64'h0, 0, 1, 0);
        add(1, 0, 0, 64'h0, 1, 31, 64'h31, 32'h0, 64'h0, 0, 1, 0);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 64'h0, 0, 1, 1);
        add(1, 0, 0, 64'h0, 0, 0, 64'h0, 32'h0, 64'h0, 0, 1, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rst_n;
            pipe_valid = vecs[i].pv; pipe_addr = vecs[i].pa; pipe_data = vecs[i].pd;
            aux_valid = vecs[i].av; aux_addr = vecs[i].aa; aux_data = vecs[i].ad;
            #2;
            chk($sformatf("v%0d_rf_wr", i), 64'(rf_wr), 64'(vecs[i].wr));
            if (vecs[i].wr != 0) chk($sformatf("v%0d_rf_in", i), rf_in, vecs[i].din);
            chk($sformatf("v%0d_stall", i), 64'(pipe_stall), 64'(vecs[i].stall));
            chk($sformatf("v%0d_ready", i), 64'(aux_ready), 64'(vecs[i].ready));
            chk($sformatf("v%0d_pend", i), 64'(aux_pending), 64'(vecs[i].pend));
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        // Randomized traffic; the pipeline holds its write across a stall.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            if (!hold) begin
                pipe_valid = ($urandom_range(0, 3) != 0);
                pipe_addr = 5'($urandom_range(0, 31));
                pipe_data = {$urandom, $urandom};
            end
            aux_valid = $urandom_range(0, 1) == 1;
            aux_addr = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            aux_data = {$urandom, $urandom};
            hold = m_forced() && pipe_valid;
            cycle(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scheduler for the 32-entry register file: merges the in-order pipeline writeback stream with writebacks from a multi-cycle auxiliary unit onto the register file's single write port. It generates the file's one-hot write-enable vector and write data. Auxiliary writes are buffered in a small FIFO, and a starvation counter guarantees they eventually drain. It sits between the writeback stage / auxiliary unit and the register file.

## Interface
- WIDTH, 64, data width; must match the register file WIDTH.
- DEPTH, 2, auxiliary FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before the auxiliary head is forced through; ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- pipe_valid  in  1  pipeline writeback valid this cycle.
- pipe_addr  in  5  pipeline destination register.
- pipe_data  in  WIDTH  pipeline write data.
- pipe_stall  out  1  forced-auxiliary cycle; the pipeline must hold pipe_* unchanged into the next cycle.
- aux_valid  in  1  auxiliary write request.
- aux_ready  out  1  FIFO can accept; transfer occurs when aux_valid & aux_ready at the edge.
- aux_addr  in  5  auxiliary destination register.
- aux_data  in  WIDTH  auxiliary write data.
- rf_wr  out  32  one-hot write enable to the register file, or all-zero.
- rf_in  out  WIDTH  write data to the register file.
- aux_pending  out  1  FIFO non-empty; used by hazard logic.

## Operation
- Each cycle, one grant: NONE, PIPE or AUX.
- Grant PIPE: pipe_valid=1 and not forced.
- Grant AUX: FIFO non-empty and either pipe_valid=0 or forced.
- Forced: starvation counter == STARVE_LIMIT and FIFO non-empty. pipe_stall=1 exactly in forced cycles, regardless of pipe_valid.
- On grant AUX, the head is dequeued at the edge.
- On grant PIPE, the pipeline write is consumed. The pipeline never waits except via pipe_stall.
- Starvation counter:
  - Increments when FIFO non-empty and grant ≠ AUX.
  - Clears on grant AUX or when FIFO empty.
  - Saturates at STARVE_LIMIT.
- Address 31 is the hard-wired zero register. A granted write to 31 drives rf_wr=0 but is still consumed: it counts as a grant, dequeues, and clears the counter.
- rf_wr = 32'b1 << addr of the granted write; all-zero on NONE or addr 31. rf_in = granted data; don't-care on NONE, 0 recommended.
- FIFO:
  - Occupancy count 0..DEPTH. aux_ready = (count < DEPTH), registered-state based.
  - When full, no enqueue, even in a dequeue cycle.
  - Simultaneous enqueue and dequeue with 0 < count < DEPTH leaves count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- No bypass: an entry enqueued at edge N is first eligible for grant in the cycle after edge N.
- Ordering: auxiliary writes retire in FIFO order. No ordering guarantee between the pipe and aux streams; hazard logic uses aux_pending.

## Timing
- rf_wr, rf_in and pipe_stall are combinational from pipe_* and registered state (FIFO head, count, counter). The register file captures at the following edge.
- Pipe latency: the write lands at the edge ending the pipe_valid cycle.
- Aux latency: minimum 2 edges from acceptance to register update (enqueue edge, then write edge).
- Worst-case aux wait under continuous pipe_valid: STARVE_LIMIT cycles lost, then a forced grant.
- Reset (reset_n=0 at an edge):
  - FIFO empties, pointers and counter go to 0.
  - While reset_n=0: rf_wr=0, pipe_stall=0, aux_ready=0, aux_pending=0.
  - Reset mid-operation discards queued writes.
  - First cycle after release: aux_ready=1.

## Structure
- Shared package regfile_pkg: REG_COUNT=32, ZERO_REG=5'd31, typedef reg_addr_t (logic [4:0]), typedef enum wb_grant_t {GRANT_NONE, GRANT_PIPE, GRANT_AUX}.
- Sub-module wb_fifo #(WIDTH+5, DEPTH): synchronous FIFO with push/pop/full/empty/count, reset_n synchronous active-low.
- The arbiter, counter and one-hot decode live in the top module.

## Test plan
- Pipe only: pipe_valid=1, addr 3, data 0xAA → rf_wr=32'h8, rf_in=0xAA, pipe_stall=0. Repeat with addr 31 → rf_wr=0.
- Aux into idle: aux write addr 5, data 0x55 accepted at edge N → cycle after N: rf_wr=32'h20, rf_in=0x55, aux_pending drops after that edge.
- Fill: 3 aux writes with pipe_valid=1 continuously, DEPTH=2 → aux_ready=0 after 2 accepts; third held until a dequeue frees space.
- Starvation: continuous pipe_valid, 1 aux entry, STARVE_LIMIT=4 → 4 PIPE grants, then one cycle with pipe_stall=1 and AUX grant; held pipe write retires the next cycle; no pipe write lost.
- Wrap: 6 alternating enqueue/dequeue pairs with DEPTH=2 → writes emerge in order with correct addresses; count never exceeds 2.
- Reset mid-operation: FIFO holds 2, assert reset_n=0 for one edge → rf_wr=0, aux_pending=0, no queued write reaches the register file; aux_ready=1 the cycle after release.
